// File: rtl/uart_tx_fifo.sv
// Byte FIFO buffering UART MMIO stores ahead of the uart_tx serializer.
// First-word-fall-through head, sticky overflow and saturating drop counter.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic              push;
  logic              pop;
  logic              drop;

  assign tx_data_valid = (level != '0);
  assign empty         = (level == '0);
  assign full          = (level == LVL_W'(DEPTH));

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = tx_data_valid && tx_data_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  assign tx_data = mem[rp];

  // NOTE: the storage array is reset so tx_data reads 0 out of reset; this
  // costs a reset net per bit but keeps the head byte defined at all times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clr) begin
      mem[wp] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr) begin
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between the memory-access stage's UART store port and the `uart_tx` serializer. A store to the UART MMIO address pulses a write into this buffer, so back-to-back stores are not lost while `uart_tx` is still shifting a previous byte out at 115200 baud. It drains to `uart_tx` over a valid/ready handshake and reports fill level and overflow for a status register.

## Interface
Parameters:
- `DEPTH`, 16, number of byte entries; must be a power of two, ≥2
- `DATA_W`, 8, entry width in bits
- `LVL_W`, $clog2(DEPTH+1), width of `level`

Ports:
- `clk`  input  1  core clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `clr`  input  1  synchronous flush; empties FIFO and clears the overflow state
- `wr_en`  input  1  write request from memory-access stage; one byte per cycle it is high
- `wr_data`  input  DATA_W  byte to enqueue
- `tx_data`  output  DATA_W  head-of-queue byte to `uart_tx`
- `tx_data_valid`  output  1  head byte present; high whenever level ≠ 0
- `tx_data_ready`  input  1  `uart_tx` accepts the head byte this cycle
- `full`  output  1  level == DEPTH
- `empty`  output  1  level == 0
- `level`  output  LVL_W  number of stored bytes, 0..DEPTH
- `overflow`  output  1  sticky; a write was dropped
- `drop_count`  output  8  saturating count of dropped writes

## Operation
- Storage: DEPTH×DATA_W register array, write pointer `wp`, read pointer `rp`, each log2(DEPTH) bits. Both wrap modulo DEPTH with natural binary rollover; no explicit compare to DEPTH-1. A separate `level` counter disambiguates full from empty.
- `pop` = `tx_data_valid` && `tx_data_ready`. On pop, `rp` increments.
- `push` = `wr_en` && (!`full` || `pop`). On push, `mem[wp]` ← `wr_data` and `wp` increments.
  - A write to a full FIFO in the same cycle as a pop is accepted.
- `level` next value is: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- `tx_data` = `mem[rp]`, a combinational read of registered storage. First-word-fall-through: the head byte is visible whenever valid.
- `tx_data` must hold stable while `tx_data_valid` is high and `tx_data_ready` is low.
- Drop: `wr_en` && `full` && !`pop`. The byte is discarded, `overflow` ← 1, and `drop_count` increments, saturating at 255.
- `clr` has priority over push and pop in the same cycle. It sets `wp` = `rp` = 0, `level` = 0, `overflow` = 0 and `drop_count` = 0. A simultaneous `wr_en` is ignored and is not counted as a drop.
- `tx_data_ready` while empty has no effect and the pointers do not move.

## Timing
- Reset values (asynchronous, immediate on `rst` assertion):
  - `wp` = `rp` = 0, `level` = 0
  - `tx_data_valid` = 0, `empty` = 1, `full` = 0
  - `overflow` = 0, `drop_count` = 0
  - `tx_data` = 0 (the storage array is reset to zero)
- Reset mid-operation: all buffered bytes are lost, with no partial state. `uart_tx` owns any byte it has already accepted.
- Write latency: a byte written at edge N into an empty FIFO appears on `tx_data`, with `tx_data_valid` = 1, immediately after edge N. That is one cycle from `wr_en` high to valid.
- `full`, `empty` and `level` are registered-derived and update after the edge that pushes or pops.
- Throughput: one push and one pop per cycle, sustained.
- Ordering: bytes leave in strict write order, including across pointer wrap-around.

## Test plan
- Reset, then write 0x48, 0x69 on consecutive cycles with `tx_data_ready` = 0.
  - After the 1st edge: valid = 1, `tx_data` = 0x48, level = 1.
  - After the 2nd edge: level = 2, `tx_data` still 0x48.
- Fill DEPTH=16 with bytes 0x00..0x0F while ready = 0, then write 0xAA.
  - Required: full = 1, level = 16, 0xAA dropped, overflow = 1, drop_count = 1.
  - Draining yields 0x00..0x0F in order.
- Full FIFO with simultaneous `wr_en` (0x55) and pop.
  - Required: level stays 16, no drop, and 0x55 emerges last after the 15 remaining bytes.
- Wrap-around: 40 writes interleaved with pops at ready duty 50%.
  - Required: output sequence equals input sequence exactly, and level never exceeds 16.
- `clr` asserted together with `wr_en` on a FIFO holding 3 bytes with overflow = 1.
  - Required, next cycle: level = 0, empty = 1, valid = 0, overflow = 0, drop_count = 0.
- Assert `rst` asynchronously mid-cycle with 5 bytes stored.
  - Required: valid drops to 0 before the next clock edge, and level = 0 after release.
- 300 writes to a full FIFO with ready = 0.
  - Required: drop_count = 255 (saturated) and overflow = 1.
